velocity_supervisor: RTL and testbench

Parametrised supervisory controller for the motor velocity loop. It sits between the quadrature decoder and the PID/PWM pair and does the following:
- selects a signed setpoint from preset switches;
- owns the edge-triggered, saturating kp/ki/kd gain registers;
- computes the registered signed error and its magnitude;
- runs a direction/brake state machine that gates the PWM onto the H-bridge control pins.

It supports both rotation directions with a braked reversal.

---
 rtl/velocity_supervisor.sv | 251 +++++++++++++++++++++++++
 tb/tb_velocity_supervisor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_supervisor.sv
// Velocity-loop supervisor: preset setpoint, gain registers, saturated error, direction/brake FSM (stall fault under VELSUP_STALL_DETECT_EN).
// Latency: setpoint 1 cycle, strobe->error 2 cycles, button->gain 2 cycles, pins 1 cycle behind i_pwm.
// Backpressure: none; free-running, every input is sampled every cycle.
module velocity_supervisor #(
    parameter int WIDTH        = 16,
    parameter int GAIN_W       = 16,
    parameter int NUM_PRESETS  = 4,
    parameter logic [NUM_PRESETS*WIDTH-1:0] PRESET_TABLE = {16'd100, 16'd50, 16'd175, 16'd75},
    parameter int DEFAULT_SP   = 150,
    parameter int KP_INIT      = 5,
    parameter int KI_INIT      = 1,
    parameter int KD_INIT      = 0,
    parameter int GAIN_MAX     = 255,
    parameter int DEADBAND     = 3,
    parameter int STOP_VEL     = 2,
    parameter int BRAKE_CYCLES = 1024,
    parameter int STALL_VEL    = 1,
    parameter int STALL_CYCLES = 1 << 20
) (
    input  logic                   Clk,
    input  logic                   n_reset,
    input  logic                   i_enable,
    input  logic [NUM_PRESETS-1:0] i_preset_sel,
    input  logic                   i_reverse,
    input  logic [WIDTH-1:0]       i_velocity,
    input  logic                   i_vel_valid,
    input  logic                   i_pwm,
    input  logic [5:0]             i_gain_btn,
    output logic [WIDTH-1:0]       o_setpoint,
    output logic [WIDTH-1:0]       o_error,
    output logic [WIDTH-1:0]       o_error_abs,
    output logic [GAIN_W-1:0]      o_kp,
    output logic [GAIN_W-1:0]      o_ki,
    output logic [GAIN_W-1:0]      o_kd,
    output logic [1:0]             o_control_pin,
    output logic [2:0]             o_state,
    output logic                   o_fault
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_CW  = 3'd1,
        ST_RUN_CCW = 3'd2,
        ST_BRAKE   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] DB_POS   = WIDTH'(DEADBAND);
    localparam logic signed [WIDTH-1:0] DB_NEG   = WIDTH'(-DEADBAND);
    localparam logic signed [WIDTH-1:0] STOP_POS = WIDTH'(STOP_VEL);
    localparam logic signed [WIDTH-1:0] STOP_NEG = WIDTH'(-STOP_VEL);
    localparam logic [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
    localparam int BCW = $clog2(BRAKE_CYCLES + 1);
    localparam logic [BCW-1:0] BRAKE_LAST = BCW'(BRAKE_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] vel_q;
    logic [WIDTH-1:0] sp_mag;
    logic [WIDTH-1:0] sp_next;
    logic             sel_onehot;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] err_sat;
    logic [WIDTH-1:0] err_abs;
    logic [5:0]       btn_q;
    logic [5:0]       btn_rise;
    logic [BCW-1:0]   brake_cnt;
    logic             sp_pos;
    logic             sp_neg;
    logic             err_hi;
    logic             err_lo;
    logic             vel_stopped;

    always_comb begin
        sel_onehot = (i_preset_sel != '0) && ((i_preset_sel & (i_preset_sel - 1'b1)) == '0);
        sp_mag = WIDTH'(DEFAULT_SP);
        if (sel_onehot) begin
            for (int i = 0; i < NUM_PRESETS; i++) begin
                if (i_preset_sel[i]) begin
                    sp_mag = PRESET_TABLE[i*WIDTH +: WIDTH];
                end
            end
        end
        sp_next = i_reverse ? -sp_mag : sp_mag;
    end

    // One extra bit of headroom so setpoint - velocity never wraps before clamping.
    always_comb begin
        diff = {o_setpoint[WIDTH-1], o_setpoint} - {vel_q[WIDTH-1], vel_q};
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            err_sat = diff[WIDTH] ? SMIN : SMAX;
        end else begin
            err_sat = diff[WIDTH-1:0];
        end
        if (!err_sat[WIDTH-1]) begin
            err_abs = err_sat;
        end else if (err_sat == SMIN) begin
            err_abs = SMAX;
        end else begin
            err_abs = -err_sat;
        end
    end

    always_ff @(posedge Clk) begin
        if (!n_reset) begin
            o_setpoint  <= '0;
            vel_q       <= '0;
            o_error     <= '0;
            o_error_abs <= '0;
        end else begin
            o_setpoint  <= sp_next;
            if (i_vel_valid) begin
                vel_q <= i_velocity;
            end
            o_error     <= err_sat;
            o_error_abs <= err_abs;
        end
    end

    function automatic logic [GAIN_W-1:0] step_gain(input logic [GAIN_W-1:0] g,
                                                    input logic up, input logic dn);
        step_gain = g;
        if (up && !dn && (g < G_MAX)) begin
            step_gain = g + 1'b1;
        end else if (dn && !up && (g != '0)) begin
            step_gain = g - 1'b1;
        end
    endfunction

    always_ff @(posedge Clk) begin
        if (!n_reset) begin
            btn_q    <= '0;
            btn_rise <= '0;
            o_kp     <= GAIN_W'(KP_INIT);
            o_ki     <= GAIN_W'(KI_INIT);
            o_kd     <= GAIN_W'(KD_INIT);
        end else begin
            btn_q    <= i_gain_btn;
            btn_rise <= i_gain_btn & ~btn_q;
            o_kp     <= step_gain(o_kp, btn_rise[0], btn_rise[1]);
            o_ki     <= step_gain(o_ki, btn_rise[2], btn_rise[3]);
            o_kd     <= step_gain(o_kd, btn_rise[4], btn_rise[5]);
        end
    end

    assign sp_pos      = !o_setpoint[WIDTH-1] && (o_setpoint != '0);
    assign sp_neg      = o_setpoint[WIDTH-1];
    assign err_hi      = $signed(o_error) > DB_POS;
    assign err_lo      = $signed(o_error) < DB_NEG;
    assign vel_stopped = ($signed(vel_q) <= STOP_POS) && ($signed(vel_q) >= STOP_NEG);

`ifdef VELSUP_STALL_DETECT_EN
    localparam int SCW = $clog2(STALL_CYCLES + 1);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYCLES - 1);
    localparam logic signed [WIDTH-1:0] STALL_POS = WIDTH'(STALL_VEL);
    localparam logic signed [WIDTH-1:0] STALL_NEG = WIDTH'(-STALL_VEL);

    logic [SCW-1:0] stall_cnt;
    logic           fault_q;
    logic           stall_cond;

    assign stall_cond = (((state == ST_RUN_CW) && o_control_pin[1]) ||
                         ((state == ST_RUN_CCW) && o_control_pin[0])) &&
                        ($signed(vel_q) <= STALL_POS) && ($signed(vel_q) >= STALL_NEG);
    assign o_fault = fault_q;
`else
    logic [63:0] unused_stall_cfg;
    assign unused_stall_cfg = {32'(STALL_VEL), 32'(STALL_CYCLES)};
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!n_reset) begin
            state         <= ST_IDLE;
            o_control_pin <= 2'b00;
            brake_cnt     <= '0;
`ifdef VELSUP_STALL_DETECT_EN
            stall_cnt     <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    o_control_pin <= 2'b00;
                    if (i_enable && sp_pos) begin
                        state <= ST_RUN_CW;
                    end else if (i_enable && sp_neg) begin
                        state <= ST_RUN_CCW;
                    end
                end
                ST_RUN_CW: begin
                    o_control_pin <= err_hi ? {i_pwm, 1'b0} : 2'b00;
                    if (!i_enable || !sp_pos) begin
                        state <= ST_BRAKE;
                    end
                end
                ST_RUN_CCW: begin
                    o_control_pin <= err_lo ? {1'b0, i_pwm} : 2'b00;
                    if (!i_enable || !sp_neg) begin
                        state <= ST_BRAKE;
                    end
                end
                ST_BRAKE: begin
                    o_control_pin <= 2'b11;
                    if (vel_stopped) begin
                        if (brake_cnt == BRAKE_LAST) begin
                            state     <= ST_IDLE;
                            brake_cnt <= '0;
                        end else begin
                            brake_cnt <= brake_cnt + 1'b1;
                        end
                    end else begin
                        brake_cnt <= '0;
                    end
                end
`ifdef VELSUP_STALL_DETECT_EN
                ST_FAULT: begin
                    o_control_pin <= 2'b00;
                    if (!i_enable) begin
                        state   <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    o_control_pin <= 2'b00;
                    state         <= ST_IDLE;
                end
            endcase
`ifdef VELSUP_STALL_DETECT_EN
            // Stall overrides any run-state decision made above on the same edge.
            if (stall_cond) begin
                if (stall_cnt == STALL_LAST) begin
                    state         <= ST_FAULT;
                    o_control_pin <= 2'b00;
                    fault_q       <= 1'b1;
                    stall_cnt     <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
`endif
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_velocity_supervisor.sv
// Self-checking bench for velocity_supervisor: randomized setpoint, error and gain traffic
// against an arithmetic reference model, plus directed FSM run/brake/reversal sequences.
module tb_velocity_supervisor;

    logic        Clk = 1'b0;
    logic        n_reset;
    logic        i_enable;
    logic [3:0]  i_preset_sel;
    logic        i_reverse;
    logic [15:0] i_velocity;
    logic        i_vel_valid;
    logic        i_pwm;
    logic [5:0]  i_gain_btn;
    logic [15:0] o_setpoint;
    logic [15:0] o_error;
    logic [15:0] o_error_abs;
    logic [15:0] o_kp;
    logic [15:0] o_ki;
    logic [15:0] o_kd;
    logic [1:0]  o_control_pin;
    logic [2:0]  o_state;
    logic        o_fault;

    velocity_supervisor dut (
        .Clk          (Clk),
        .n_reset      (n_reset),
        .i_enable     (i_enable),
        .i_preset_sel (i_preset_sel),
        .i_reverse    (i_reverse),
        .i_velocity   (i_velocity),
        .i_vel_valid  (i_vel_valid),
        .i_pwm        (i_pwm),
        .i_gain_btn   (i_gain_btn),
        .o_setpoint   (o_setpoint),
        .o_error      (o_error),
        .o_error_abs  (o_error_abs),
        .o_kp         (o_kp),
        .o_ki         (o_ki),
        .o_kd         (o_kd),
        .o_control_pin(o_control_pin),
        .o_state      (o_state),
        .o_fault      (o_fault)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int kg[3];

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: presets indexed by select bit, default 150 otherwise, sign from reverse.
    function automatic int exp_sp(input logic [3:0] sel, input logic rev);
        int tbl[4];
        int m;
        tbl = '{75, 175, 50, 100};
        m = 150;
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) m = tbl[i];
        end
        return rev ? -m : m;
    endfunction

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int abs16(input int e);
        if (e == -32768) return 32767;
        return (e < 0) ? -e : e;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input int v);
        i_velocity  = 16'(v);
        i_vel_valid = 1'b1;
        tick();
        i_vel_valid = 1'b0;
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    task automatic pulse(input logic [5:0] b);
        i_gain_btn = b;
        tick();
        i_gain_btn = 6'b0;
        tick();
    endtask

    task automatic model_pulse(input logic [5:0] b);
        for (int g = 0; g < 3; g++) begin
            if (b[2*g] && !b[2*g+1]) kg[g] = (kg[g] < 255) ? kg[g] + 1 : 255;
            else if (b[2*g+1] && !b[2*g]) kg[g] = (kg[g] > 0) ? kg[g] - 1 : 0;
        end
    endtask

    task automatic check_gains(input string tag);
        check({tag, "_kp"}, int'(o_kp), kg[0]);
        check({tag, "_ki"}, int'(o_ki), kg[1]);
        check({tag, "_kd"}, int'(o_kd), kg[2]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] sel_t[4];
        logic       rev_t[4];
        int         sp_t[4];
        int         sp;
        int         v;
        int         e;
        int         n;
        logic [5:0] b;

        n_reset = 1'b0; i_enable = 1'b0; i_preset_sel = 4'b0; i_reverse = 1'b0;
        i_velocity = 16'd0; i_vel_valid = 1'b0; i_pwm = 1'b0; i_gain_btn = 6'b0;
        tick_n(2);
        check("rst_setpoint", sx(o_setpoint), 0);
        check("rst_error", sx(o_error), 0);
        check("rst_error_abs", sx(o_error_abs), 0);
        check("rst_kp", int'(o_kp), 5);
        check("rst_ki", int'(o_ki), 1);
        check("rst_kd", int'(o_kd), 0);
        check("rst_pins", int'(o_control_pin), 0);
        check("rst_state", int'(o_state), 0);
        check("rst_fault", int'(o_fault), 0);
        n_reset = 1'b1;

        sel_t = '{4'b0001, 4'b0100, 4'b0011, 4'b0010};
        rev_t = '{1'b0, 1'b0, 1'b0, 1'b1};
        sp_t  = '{75, 50, 150, -175};
        for (int i = 0; i < 4; i++) begin
            i_preset_sel = sel_t[i];
            i_reverse    = rev_t[i];
            tick();
            check("preset_dir", sx(o_setpoint), sp_t[i]);
        end

        for (int i = 0; i < 30; i++) begin
            i_preset_sel = 4'($urandom);
            i_reverse    = 1'($urandom);
            tick();
            check("preset_rand", sx(o_setpoint), exp_sp(i_preset_sel, i_reverse));
            check("idle_hold", int'(o_state), 0);
        end

        for (int i = 0; i < 40; i++) begin
            i_preset_sel = 4'($urandom);
            i_reverse    = 1'($urandom);
            if ($urandom_range(0, 3) == 0) v = sx(16'($urandom));
            else v = int'($urandom_range(0, 400)) - 200;
            strobe(v);
            tick();
            e = clamp16(exp_sp(i_preset_sel, i_reverse) - v);
            check("err_rand", sx(o_error), e);
            check("err_abs_rand", sx(o_error_abs), abs16(e));
        end

        i_preset_sel = 4'b0010; i_reverse = 1'b0;
        strobe(-32768);
        tick();
        check("err_sat_pos", sx(o_error), 32767);
        check("err_abs_sat_pos", sx(o_error_abs), 32767);
        i_reverse = 1'b1;
        strobe(32767);
        tick();
        check("err_sat_neg", sx(o_error), -32768);
        check("err_abs_sat_neg", sx(o_error_abs), 32767);

        i_velocity = 16'd1234;
        tick_n(2);
        check("vel_hold", sx(o_error), -32768);

        n_reset = 1'b0; i_vel_valid = 1'b1; i_velocity = 16'd1000;
        tick();
        n_reset = 1'b1; i_vel_valid = 1'b0;
        tick_n(2);
        check("reset_beats_valid", sx(o_error), exp_sp(4'b0010, 1'b1));

        apply_reset();
        kg = '{5, 1, 0};
        i_gain_btn = 6'b000001;
        tick();
        check("kp_lat_1cyc", int'(o_kp), 5);
        tick();
        check("kp_lat_2cyc", int'(o_kp), 6);
        tick_n(298);
        check("kp_hold_300", int'(o_kp), 6);
        i_gain_btn = 6'b0;
        tick();
        kg[0] = 6;
        for (int i = 0; i < 260; i++) begin
            pulse(6'b000001);
            model_pulse(6'b000001);
        end
        check("kp_ceiling", int'(o_kp), 255);
        check_gains("after_260");
        pulse(6'b000011);
        model_pulse(6'b000011);
        check_gains("kp_up_dn_same");
        apply_reset();
        kg = '{5, 1, 0};
        for (int i = 0; i < 6; i++) begin
            pulse(6'b000010);
            model_pulse(6'b000010);
        end
        check("kp_floor", int'(o_kp), 0);
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0: b = 6'b000001 << (2 * n);
                1: b = 6'b000010 << (2 * n);
                default: b = 6'b000011 << (2 * n);
            endcase
            pulse(b);
            model_pulse(b);
            check_gains("gain_rand");
        end

        apply_reset();
        i_preset_sel = 4'b0001; i_reverse = 1'b0;
        strobe(60);
        tick_n(2);
        check("run_err_15", sx(o_error), 15);
        i_enable = 1'b1;
        tick();
        check("enter_cw", int'(o_state), 1);
        for (int i = 0; i < 16; i++) begin
            i_pwm = 1'($urandom);
            tick();
            check("cw_pins", int'(o_control_pin), i_pwm ? 2 : 0);
        end
        i_pwm = 1'b1;
        strobe(77);
        tick();
        check("run_err_m2", sx(o_error), -2);
        tick();
        check("cw_coast", int'(o_control_pin), 0);
        for (int i = 0; i < 8; i++) begin
            i_pwm = 1'($urandom);
            tick();
            check("cw_coast_rand", int'(o_control_pin), 0);
        end
        check("cw_stay", int'(o_state), 1);

        strobe(100);
        tick();
        i_reverse = 1'b1;
        tick();
        check("rev_setpoint", sx(o_setpoint), -75);
        tick();
        check("enter_brake", int'(o_state), 3);
        tick();
        check("brake_pins", int'(o_control_pin), 3);
        tick_n(20);
        check("brake_moving", int'(o_state), 3);
        strobe(1);
        tick_n(500);
        check("brake_mid", int'(o_state), 3);
        strobe(5);
        strobe(1);
        n = 0;
        while (o_state == 3'd3 && n < 3000) begin
            tick();
            n++;
        end
        check("brake_exit_cycles", n, 1024);
        check("brake_to_idle", int'(o_state), 0);
        tick();
        check("enter_ccw", int'(o_state), 2);
        for (int i = 0; i < 12; i++) begin
            i_pwm = 1'($urandom);
            tick();
            check("ccw_pins", int'(o_control_pin), i_pwm ? 1 : 0);
        end
        check("no_fault", int'(o_fault), 0);

        i_enable = 1'b0;
        tick();
        check("disable_brake", int'(o_state), 3);
        n_reset = 1'b0;
        tick();
        check("rst_in_brake_pins", int'(o_control_pin), 0);
        check("rst_in_brake_state", int'(o_state), 0);
        n_reset = 1'b1;
        i_enable = 1'b1;
        tick_n(2);
        check("reenter_ccw", int'(o_state), 2);
        i_pwm = 1'b1;
        tick();
        check("ccw_drive", int'(o_control_pin), 1);
        n_reset = 1'b0;
        tick();
        check("rst_in_run_pins", int'(o_control_pin), 0);
        check("rst_in_run_state", int'(o_state), 0);
        n_reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
